// File: rtl/cos_host_pkg.sv
// Shared types and widths for the cosine-engine host and its FIFOs.
package cos_host_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 8;
    localparam int INT_W  = 2;
    localparam int FRAC_W = 8;
    localparam int RES_W  = INT_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        PUSH
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cmd_t;

    typedef struct packed {
        logic              err;
        logic [INT_W-1:0]  ip;
        logic [FRAC_W-1:0] fp;
    } res_t;

endpackage

// File: rtl/cos_host_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head stage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_mcnt;
    logic             r_hvalid;
    logic [WIDTH-1:0] r_head;

    logic             w_wr;
    logic             w_rd;
    logic             w_load;
    logic [AW:0]      w_total;

    // Occupancy counts the memory plus the head register, so full is exact.
    assign w_total = r_mcnt + {{AW{1'b0}}, r_hvalid};
    assign full    = (w_total == FULL_CNT);
    assign empty   = !r_hvalid;
    assign rd_data = r_head;
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && r_hvalid;
    assign w_load  = (r_mcnt != '0) && (!r_hvalid || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_mcnt   <= '0;
            r_hvalid <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_load) begin
                r_head <= r_mem[r_rptr];
                r_rptr <= r_rptr + AW'(1);
            end
            r_mcnt <= r_mcnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_load};
            if (w_load) begin
                r_hvalid <= 1'b1;
            end else if (w_rd) begin
                r_hvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cos_host.sv
// Host for the cosine engine: queues operand pairs, runs one engine operation
// at a time with a done timeout, and queues results for the consumer.
module cos_host
    import cos_host_pkg::*;
#(
    parameter int CMD_DEPTH    = 4,
    parameter int RES_DEPTH    = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    output logic              eng_start,
    output logic [X_W-1:0]    eng_x,
    output logic [Y_W-1:0]    eng_y,
    input  logic              eng_done,
    input  logic [INT_W-1:0]  eng_intpart,
    input  logic [FRAC_W-1:0] eng_fracpart,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy
);

    localparam int SCW = $clog2(START_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(START_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [SCW-1:0]  r_scnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_done_q;
    logic [X_W-1:0]  r_eng_x;
    logic [Y_W-1:0]  r_eng_y;
    res_t            r_res;

    cmd_t            w_cmd_in;
    cmd_t            w_cmd_head;
    res_t            w_res_head;
    logic            w_cmd_wr;
    logic            w_cmd_full;
    logic            w_cmd_empty;
    logic            w_res_full;
    logic            w_res_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_rise;
    logic            w_capture;
    logic            w_timeout;

    assign w_cmd_in = {cmd_x, cmd_y};
    assign w_cmd_wr = cmd_valid && cmd_ready;
    assign w_rise   = eng_done && !r_done_q;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_cmd_wr),
        .wr_data (w_cmd_in),
        .rd_en   (w_pop),
        .rd_data (w_cmd_head),
        .full    (w_cmd_full),
        .empty   (w_cmd_empty)
    );

    sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (r_res),
        .rd_en   (res_ready),
        .rd_data (w_res_head),
        .full    (w_res_full),
        .empty   (w_res_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A done edge in the final WAIT cycle takes priority over the timeout.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_push    = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cmd_empty && !w_res_full) begin
                    w_pop  = 1'b1;
                    w_next = START;
                end
            end
            START: begin
                if (r_scnt == SC_LAST) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    w_next    = PUSH;
                end else if (r_tcnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = PUSH;
                end
            end
            PUSH: begin
                w_push = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scnt   <= '0;
            r_tcnt   <= '0;
            r_done_q <= 1'b0;
            r_eng_x  <= '0;
            r_eng_y  <= '0;
            r_res    <= '0;
        end else begin
            r_done_q <= eng_done;
            if (w_pop) begin
                r_eng_x <= w_cmd_head.x;
                r_eng_y <= w_cmd_head.y;
                r_scnt  <= '0;
            end else if (r_state == START) begin
                r_scnt <= r_scnt + SCW'(1);
            end
            if (r_state == START) begin
                r_tcnt <= '0;
            end else if (r_state == WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_capture) begin
                r_res <= {1'b0, eng_intpart, eng_fracpart};
            end else if (w_timeout) begin
                r_res <= {1'b1, {RES_W{1'b0}}};
            end
        end
    end

    assign cmd_ready = rst && !w_cmd_full;
    assign eng_start = (r_state == START);
    assign eng_x     = r_eng_x;
    assign eng_y     = r_eng_y;
    assign busy      = (r_state != IDLE);
    assign res_valid = !w_res_empty;
    assign res_data  = {w_res_head.ip, w_res_head.fp};
    assign res_err   = w_res_head.err;

endmodule

// File: tb/tb_cos_host.sv
// Directed bench for cos_host: behavioural engine, transaction scoreboard
// and hand-computed latency/data expectations.
module tb_cos_host;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic       eng_start;
    logic [9:0] eng_x;
    logic [7:0] eng_y;
    logic       eng_done = 1'b0;
    logic [1:0] eng_intpart = '0;
    logic [7:0] eng_fracpart = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [9:0] res_data;
    logic       res_err;
    logic       busy;

    always #5 clk = ~clk;

    cos_host #(
        .CMD_DEPTH    (4),
        .RES_DEPTH    (4),
        .START_CYCLES (2),
        .TIMEOUT      (1023)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .eng_start    (eng_start),
        .eng_x        (eng_x),
        .eng_y        (eng_y),
        .eng_done     (eng_done),
        .eng_intpart  (eng_intpart),
        .eng_fracpart (eng_fracpart),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
        .busy         (busy)
    );

    typedef struct {
        logic [9:0] x;
        logic [7:0] y;
    } op_t;

    int         n_pass = 0;
    int         n_total = 0;
    int         n_starts = 0;
    op_t        cmd_q[$];
    logic [10:0] exp_q[$];

    // engine modes: 0 = done after e_delay, 1 = stale hold then re-raise, 2 = never done
    int         e_mode = 0;
    int         e_delay = 20;
    int         e_cnt = 0;
    logic       e_prev = 1'b0;
    logic       e_pend = 1'b0;
    logic [7:0] e_y = '0;

    logic       c_prev = 1'b0;
    int         c_run = 0;
    logic       c_have = 1'b0;
    logic [9:0] c_x = '0;
    logic [7:0] c_y = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] resp(input logic [7:0] y);
        logic [7:0] f;
        f = y ^ 8'hA5;
        return (y == 8'h80) ? 10'h0B7 : {y[1:0], f};
    endfunction

    // Behavioural engine, reacting just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (eng_start && !e_prev) begin
                e_y    = eng_y;
                e_pend = 1'b0;
                if (e_mode != 1) eng_done = 1'b0;
            end
            if (!eng_start && e_prev) begin
                e_pend = 1'b1;
                e_cnt  = 0;
            end else if (e_pend) begin
                e_cnt++;
                if (e_mode == 0 && e_cnt == e_delay) begin
                    {eng_intpart, eng_fracpart} = resp(e_y);
                    eng_done = 1'b1;
                    e_pend   = 1'b0;
                end else if (e_mode == 1 && e_cnt == e_delay) begin
                    eng_done = 1'b0;
                end else if (e_mode == 1 && e_cnt == 2 * e_delay) begin
                    {eng_intpart, eng_fracpart} = resp(e_y);
                    eng_done = 1'b1;
                    e_pend   = 1'b0;
                end
            end
            e_prev = eng_start;
        end
    end

    // Compare process: operand order/stability, start width, result stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                c_prev = 1'b0;
                c_run  = 0;
                c_have = 1'b0;
                continue;
            end
            if (eng_start) begin
                if (!c_prev) begin
                    n_starts++;
                    if (cmd_q.size() == 0) begin
                        n_total++;
                        $display("FAIL start_no_cmd: eng_start rose with no queued command");
                    end else begin
                        op_t op;
                        op = cmd_q.pop_front();
                        chk("eng_x_at_start", eng_x, op.x);
                        chk("eng_y_at_start", eng_y, op.y);
                        c_x    = op.x;
                        c_y    = op.y;
                        c_have = 1'b1;
                    end
                end
                c_run++;
            end else if (c_prev) begin
                chk("start_width", c_run, 2);
                c_run = 0;
            end
            if (busy && c_have) begin
                chk("eng_x_hold", eng_x, c_x);
                chk("eng_y_hold", eng_y, c_y);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL res_unexpected: res_data=0x%0h err=%0b with nothing expected", res_data, res_err);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e[9:0]);
                    chk("res_err", res_err, e[10]);
                end
            end
            c_prev = eng_start;
        end
    end

    task automatic push_cmd(input logic [9:0] x, input logic [7:0] y, input logic [10:0] e);
        bit ok;
        op_t op;
        ok = 1'b0;
        cmd_x = x;
        cmd_y = y;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL push_timeout: cmd_ready stayed 0 for y=0x%0h", y);
        end else begin
            op.x = x;
            op.y = y;
            cmd_q.push_back(op);
            exp_q.push_back(e);
        end
    endtask

    // Cycles from the falling edge of eng_start to res_valid, -1 on expiry.
    task automatic measure(output int n);
        int k;
        k = 0;
        while (!eng_start && k < 3000) begin @(negedge clk); k++; end
        while (eng_start && k < 3000) begin @(negedge clk); k++; end
        if (k >= 3000) begin
            n = -1;
        end else begin
            n = 0;
            while (!res_valid && n < 3000) begin tick(); n++; end
            if (n >= 3000) n = -1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    logic [9:0] bp_exp [8] = '{10'h1A4, 10'h2A7, 10'h3A6, 10'h0A1,
                               10'h1A0, 10'h2A3, 10'h3A2, 10'h0AD};

    initial begin
        int n;
        int s0;
        int k;

        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_x", eng_x, 0);
        chk("rst_eng_y", eng_y, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // single operation
        res_ready = 1'b1;
        e_mode = 0;
        e_delay = 20;
        push_cmd(10'b0110000000, 8'h80, {1'b0, 10'h0B7});
        tick();
        chk("lat_start_n1", eng_start, 0);
        tick();
        chk("lat_start_n2", eng_start, 1);
        chk("single_eng_x", eng_x, 10'h180);
        measure(n);
        chk("single_latency", n, 23);
        chk("single_res_data", res_data, 10'h0B7);
        chk("single_res_err", res_err, 0);
        tick();
        chk("single_busy_idle", busy, 0);

        // back-pressure: fill result FIFO, then command FIFO
        res_ready = 1'b0;
        e_delay = 2;
        for (int i = 1; i <= 4; i++) push_cmd(10'(i * 37), 8'(i), {1'b0, bp_exp[i-1]});
        repeat (80) tick();
        chk("bp_res_valid", res_valid, 1);
        s0 = n_starts;
        for (int i = 5; i <= 8; i++) push_cmd(10'(i * 37), 8'(i), {1'b0, bp_exp[i-1]});
        chk("bp_cmd_ready_full", cmd_ready, 0);
        repeat (30) tick();
        chk("bp_no_start", n_starts - s0, 0);
        chk("bp_busy", busy, 0);
        res_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin tick(); k++; end
        chk("bp_drained", exp_q.size(), 0);
        repeat (3) tick();

        // stale done from the previous operation must be ignored
        e_mode = 1;
        e_delay = 5;
        push_cmd(10'h155, 8'h10, {1'b0, 10'h0B5});
        measure(n);
        chk("stale_latency", n, 13);
        chk("stale_res_data", res_data, 10'h0B5);
        repeat (3) tick();

        // timeout
        e_mode = 2;
        push_cmd(10'h200, 8'h20, {1'b1, 10'h000});
        measure(n);
        chk("timeout_latency", n, 1025);
        chk("timeout_res_err", res_err, 1);
        chk("timeout_res_data", res_data, 0);
        repeat (3) tick();

        // done edge in the final WAIT cycle wins over timeout
        e_mode = 0;
        e_delay = 1022;
        push_cmd(10'h0AA, 8'h33, {1'b0, 10'h396});
        measure(n);
        chk("coincide_latency", n, 1025);
        chk("coincide_res_err", res_err, 0);
        chk("coincide_res_data", res_data, 10'h396);
        repeat (3) tick();

        // reset in the middle of an operation
        e_delay = 3;
        res_ready = 1'b0;
        push_cmd(10'h111, 8'h01, {1'b0, 10'h1A4});
        k = 0;
        while (!res_valid && k < 100) begin tick(); k++; end
        chk("mid_pre_res_valid", res_valid, 1);
        e_mode = 2;
        push_cmd(10'h222, 8'h02, {1'b0, 10'h2A7});
        push_cmd(10'h333, 8'h03, {1'b0, 10'h3A6});
        k = 0;
        while (!eng_start && k < 100) begin tick(); k++; end
        chk("mid_start_seen", eng_start, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_eng_start", eng_start, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        chk("mid_busy", busy, 0);
        cmd_q.delete();
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_post_cmd_ready", cmd_ready, 1);
        res_ready = 1'b1;
        s0 = n_starts;
        repeat (20) tick();
        chk("mid_queue_gone", n_starts - s0, 0);
        chk("mid_post_res_valid", res_valid, 0);
        chk("mid_post_busy", busy, 0);

        chk("leftover_results", exp_q.size(), 0);
        chk("leftover_cmds", cmd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cos_host.md
Name: cos_host

Overview:
- Initiator/host for the fixed-point cosine engine (`coss`).
- Accepts operand pairs (x, y) on a valid/ready command stream and buffers them.
- Drives the engine's start/x/y handshake one operation at a time, captures done/intpart/fracpart, and returns results on a valid/ready result stream.
- Sits between a system sequencer and the engine; adds queuing, back-pressure and a done timeout.

Parameters:
- CMD_DEPTH, 4: command FIFO entries (power of 2, >=2).
- RES_DEPTH, 4: result FIFO entries (power of 2, >=2).
- START_CYCLES, 2: cycles eng_start is held high per operation (>=1).
- TIMEOUT, 1023: max WAIT cycles before an error result is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_x  in  10  operand x.
- cmd_y  in  8  operand y.
- eng_start  out  1  engine start.
- eng_x  out  10  engine x, held stable from pop until capture.
- eng_y  out  8  engine y, held stable from pop until capture.
- eng_done  in  1  engine done (level).
- eng_intpart  in  2  engine integer result.
- eng_fracpart  in  8  engine fraction result.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  result consumed.
- res_data  out  10  {intpart, fracpart} of head entry.
- res_err  out  1  head entry is a timeout result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; both FIFOs empty.
  - eng_start=0, eng_x=0, eng_y=0, res_valid=0, res_data=0, res_err=0, busy=0; cmd_ready=0 while in reset.
  - An in-flight operation is discarded. eng_start falls immediately, without waiting for a clock edge.
- Command accept: cmd_valid&&cmd_ready at an edge writes {x,y}. cmd_ready = !cmd_full. A write when full is impossible by construction.
- States: IDLE, START, WAIT, PUSH.
  - IDLE: if cmd FIFO non-empty AND result FIFO not full:
    - pop the command;
    - register eng_x/eng_y;
    - clear the start counter;
    - go to START.
    - Only one operation is ever in flight, so a slot is guaranteed at PUSH.
  - START:
    - eng_start=1 for exactly START_CYCLES cycles, beginning the cycle after the pop edge.
    - Then eng_start=0; clear the timeout counter; go to WAIT.
  - WAIT:
    - done_q registers eng_done each cycle.
    - On a rising edge (eng_done && !done_q), capture {eng_intpart, eng_fracpart} with err=0; go to PUSH.
    - A done level already high on entry (stale from a previous operation) is ignored until it falls and rises again.
    - Timeout counter increments each WAIT cycle. At TIMEOUT, capture data=0, err=1; go to PUSH.
    - A done edge and the timeout in the same cycle: done wins.
  - PUSH: write the captured entry to the result FIFO (one cycle); go to IDLE.
- Latency:
  - Command accepted at edge N → eng_start rises after edge N+2 (FIFO write, then pop from IDLE).
  - Done rising edge sampled at edge M → res_valid=1 after edge M+2 when the result FIFO was empty.
- Simultaneous events:
  - Command FIFO push and pop in the same cycle is legal; count is unchanged.
  - Result push and pop in the same cycle is legal.
  - res_ready while res_valid=0 is ignored.
- FIFO pointers wrap modulo depth. Full/empty come from an extra pointer bit or a count register. Data output is registered at the head (first-word-fall-through).
- eng_x/eng_y change only at the IDLE→START transition.

Decomposition:
- Package cos_host_pkg:
  - state enum (IDLE, START, WAIT, PUSH);
  - localparams X_W=10, Y_W=8, INT_W=2, FRAC_W=8, RES_W=INT_W+FRAC_W;
  - packed struct cmd_t {x,y} and res_t {err,int,frac}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty). Instantiated twice: command and result.

Test Plan:
- Single op: cmd x=10'b0110000000, y=8'h80; behavioural engine asserts done 20 cycles after start falls with int=2'b00, frac=8'hB7.
  - Required: eng_start high for exactly 2 cycles.
  - Required: eng_x=0x180 stable throughout.
  - Required: res_data=10'h0B7, res_err=0, busy returns to 0.
- Back-pressure: push 4 commands with res_ready=0.
  - Required: cmd_ready deasserts after the 4th.
  - Required: after 4 results fill the result FIFO, no further eng_start occurs.
  - Then res_ready=1 → queue drains in order (tags via distinct y=1..4).
- Stale done: engine holds done high from the previous op.
  - Required: the new op is not completed until done falls and rises.
  - Required: the result matches the second engine response.
- Timeout: engine never asserts done.
  - Required: exactly 1023 WAIT cycles later, a result with res_err=1, res_data=0.
  - Required: the next command is issued normally afterwards.
- Mid-op reset: assert rst=0 during WAIT.
  - Required: eng_start=0, res_valid=0, cmd_ready=0 immediately.
  - After release, cmd_ready=1; the earlier queued commands are gone.
- Done and timeout coincide at count 1023.
  - Required: res_err=0, engine data captured.
